fxp_encode_pipe: RTL

- Converts signed integer samples (colour-channel differences, thresholds) into signed Q-format fixed point for the colour-detection arithmetic datapath.
- Conversion is an arithmetic left shift by SN fractional bits, saturated to N bits. It is the inverse of the datapath's fixed-point-to-integer right-shift rescale.
- Two-stage valid/ready pipeline with back-pressure, a per-sample saturation flag and a sticky saturation counter.

---
 rtl/fxp_encode_pipe.sv | 103 ++++++++++
 1 files changed

// File: rtl/fxp_encode_pipe.sv
// rtl/fxp_encode_pipe.sv - signed integer to saturated Q-format converter, 2-stage valid/ready pipe
module fxp_encode_pipe #(
  parameter int IW = 10,
  parameter int N  = 20,
  parameter int SN = 12,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [IW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [N-1:0]  out_data,
  output logic                 out_sat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        sat_count,
  input  logic                 sat_clear
);

  localparam int EW = IW + SN;

  logic                 s1_valid;
  logic signed [EW-1:0] s1_v;
  logic signed [EW-1:0] ext;
  logic                 s1_load;
  logic                 s2_load;
  logic signed [N-1:0]  sat_data;
  logic                 sat_flag;
  logic                 sat_inc;

  // Left shift is exact at EW bits, so no information is lost before the clamp.
  assign ext = EW'(in_data) <<< SN;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = reset_n && s1_load;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_v     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_v <= ext;
      end
    end
  end

  generate
    if (EW > N) begin : g_clamp
      localparam logic signed [N-1:0]  MAX_N = {1'b0, {(N-1){1'b1}}};
      localparam logic signed [N-1:0]  MIN_N = {1'b1, {(N-1){1'b0}}};
      localparam logic signed [EW-1:0] MAX_E = EW'(MAX_N);
      localparam logic signed [EW-1:0] MIN_E = EW'(MIN_N);

      always_comb begin
        sat_data = s1_v[N-1:0];
        sat_flag = 1'b0;
        if (s1_v > MAX_E) begin
          sat_data = MAX_N;
          sat_flag = 1'b1;
        end else if (s1_v < MIN_E) begin
          sat_data = MIN_N;
          sat_flag = 1'b1;
        end
      end
    end else begin : g_pass
      // The shifted value always fits; only sign extension is needed.
      assign sat_data = N'(s1_v);
      assign sat_flag = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sat_data;
        out_sat  <= sat_flag;
      end
    end
  end

  assign sat_inc = s2_load && s1_valid && sat_flag;

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= '0;
    end else if (sat_inc && (sat_count != {CW{1'b1}})) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule
